// File: rtl/game_state_ctl.sv
// Penalty game controller: click-edge detect, START/AIM/RESULT flow, shot judging, score and screen select.
// Latency: a click or vsync tick seen in cycle N is reflected on the registered outputs in cycle N+1.
// Backpressure: none; events arriving in a state that does not use them are dropped (clicks in RESULT).
// Optional feature macro: KEEPER_RANDOM_EN (LFSR-driven keeper dive; centre dive when undefined).
module game_state_ctl #(
    parameter int GOAL_X_MIN    = 212,
    parameter int GOAL_X_MAX    = 812,
    parameter int GOAL_Y_MIN    = 150,
    parameter int GOAL_Y_MAX    = 450,
    parameter int SHOTS         = 5,
    parameter int RESULT_FRAMES = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        left,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        vsync,
    output logic [1:0]  screen_sel,
    output logic        shot_valid,
    output logic [11:0] shot_x,
    output logic [11:0] shot_y,
    output logic        goal,
    output logic [1:0]  keeper_sector,
    output logic [3:0]  score,
    output logic [3:0]  shots_taken
);

    // Goal box split into three equal-width sectors: left, centre, right.
    localparam int          THIRD  = (GOAL_X_MAX - GOAL_X_MIN) / 3;
    localparam logic [11:0] X_MIN  = 12'(GOAL_X_MIN);
    localparam logic [11:0] X_MAX  = 12'(GOAL_X_MAX);
    localparam logic [11:0] Y_MIN  = 12'(GOAL_Y_MIN);
    localparam logic [11:0] Y_MAX  = 12'(GOAL_Y_MAX);
    localparam logic [11:0] X_S1   = 12'(GOAL_X_MIN + THIRD);
    localparam logic [11:0] X_S2   = 12'(GOAL_X_MIN + 2 * THIRD);
    localparam logic [3:0]  SHOTS4 = 4'(SHOTS);

    // Frame counter only needs to reach RESULT_FRAMES-1; the last tick triggers the exit.
    localparam int            FW     = (RESULT_FRAMES > 1) ? $clog2(RESULT_FRAMES) : 1;
    localparam logic [FW-1:0] F_LAST = FW'(RESULT_FRAMES - 1);

    typedef enum logic [1:0] {
        S_START  = 2'd0,
        S_AIM    = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t        r_state, w_state_nx;
    logic          r_left_q, r_vsync_q;
    logic [FW-1:0] r_frames, w_frames_nx;
    logic [1:0]    r_sel, w_sel_nx;
    logic          r_valid, w_valid_nx;
    logic [11:0]   r_shot_x, w_shot_x_nx;
    logic [11:0]   r_shot_y, w_shot_y_nx;
    logic          r_goal, w_goal_nx;
    logic [1:0]    r_keeper, w_keeper_nx;
    logic [3:0]    r_score, w_score_nx;
    logic [3:0]    r_shots, w_shots_nx;

    logic          w_click, w_tick;
    logic          w_in_box;
    logic [1:0]    w_sector;
    logic [1:0]    w_dive;
    logic          w_goal;

    assign w_click = left & ~r_left_q;
    assign w_tick  = vsync & ~r_vsync_q;

`ifdef KEEPER_RANDOM_EN
    logic [7:0] r_lfsr;
    logic       w_fb;

    // x^8+x^6+x^5+x^4+1 is maximal length, so a non-zero seed never reaches zero.
    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // Free-running keeper randomiser, advances every clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_lfsr <= 8'hA5;
        else     r_lfsr <= {r_lfsr[6:0], w_fb};
    end

    // Two random bits give four codes; the spare code also dives centre.
    assign w_dive = (r_lfsr[1:0] == 2'd3) ? 2'd1 : r_lfsr[1:0];
`else
    assign w_dive = 2'd1;
`endif

    // Shot judging on the live cursor position of the click cycle.
    assign w_in_box = (xpos >= X_MIN) && (xpos < X_MAX) && (ypos >= Y_MIN) && (ypos < Y_MAX);
    assign w_sector = (xpos < X_S1) ? 2'd0 : ((xpos < X_S2) ? 2'd1 : 2'd2);
    assign w_goal   = w_in_box && (w_sector != w_dive);

    // Edge-detect history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_left_q  <= 1'b0;
            r_vsync_q <= 1'b0;
        end else begin
            r_left_q  <= left;
            r_vsync_q <= vsync;
        end
    end

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        w_state_nx  = r_state;
        w_frames_nx = r_frames;
        w_sel_nx    = r_sel;
        w_valid_nx  = 1'b0;
        w_shot_x_nx = r_shot_x;
        w_shot_y_nx = r_shot_y;
        w_goal_nx   = r_goal;
        w_keeper_nx = r_keeper;
        w_score_nx  = r_score;
        w_shots_nx  = r_shots;
        case (r_state)
            S_START: begin
                if (w_click) begin
                    w_state_nx = S_AIM;
                    w_sel_nx   = 2'd1;
                    w_score_nx = 4'd0;
                    w_shots_nx = 4'd0;
                end
            end
            S_AIM: begin
                if (w_click) begin
                    w_state_nx  = S_RESULT;
                    w_sel_nx    = w_goal ? 2'd2 : 2'd3;
                    w_valid_nx  = 1'b1;
                    w_shot_x_nx = xpos;
                    w_shot_y_nx = ypos;
                    w_goal_nx   = w_goal;
                    w_keeper_nx = w_dive;
                    w_shots_nx  = r_shots + 4'd1;
                    w_score_nx  = r_score + {3'd0, w_goal};
                    w_frames_nx = '0;
                end
            end
            S_RESULT: begin
                if (w_tick) begin
                    if (r_frames == F_LAST) begin
                        w_frames_nx = '0;
                        if (r_shots < SHOTS4) begin
                            w_state_nx = S_AIM;
                            w_sel_nx   = 2'd1;
                        end else begin
                            w_state_nx = S_START;
                            w_sel_nx   = 2'd0;
                        end
                    end else begin
                        w_frames_nx = r_frames + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = S_START;
                w_sel_nx   = 2'd0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_START;
            r_frames <= '0;
            r_sel    <= 2'd0;
            r_valid  <= 1'b0;
            r_shot_x <= 12'd0;
            r_shot_y <= 12'd0;
            r_goal   <= 1'b0;
            r_keeper <= 2'd1;
            r_score  <= 4'd0;
            r_shots  <= 4'd0;
        end else begin
            r_state  <= w_state_nx;
            r_frames <= w_frames_nx;
            r_sel    <= w_sel_nx;
            r_valid  <= w_valid_nx;
            r_shot_x <= w_shot_x_nx;
            r_shot_y <= w_shot_y_nx;
            r_goal   <= w_goal_nx;
            r_keeper <= w_keeper_nx;
            r_score  <= w_score_nx;
            r_shots  <= w_shots_nx;
        end
    end

    assign screen_sel    = r_sel;
    assign shot_valid    = r_valid;
    assign shot_x        = r_shot_x;
    assign shot_y        = r_shot_y;
    assign goal          = r_goal;
    assign keeper_sector = r_keeper;
    assign score         = r_score;
    assign shots_taken   = r_shots;

endmodule

// File: tb/tb_game_state_ctl.sv
// Directed bench for game_state_ctl with SHOTS=2, RESULT_FRAMES=2, centre keeper.
// Expected shot records are queued at the click and checked when shot_valid appears.
// Stimulus drives and samples 1 ns after the rising clock edge.
module tb_game_state_ctl;

    logic        clk;
    logic        rst;
    logic        left;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        vsync;
    logic [1:0]  screen_sel;
    logic        shot_valid;
    logic [11:0] shot_x;
    logic [11:0] shot_y;
    logic        goal;
    logic [1:0]  keeper_sector;
    logic [3:0]  score;
    logic [3:0]  shots_taken;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        g;
        logic [1:0]  k;
    } shot_t;

    shot_t exp_q[$];

    game_state_ctl #(
        .GOAL_X_MIN   (212),
        .GOAL_X_MAX   (812),
        .GOAL_Y_MIN   (150),
        .GOAL_Y_MAX   (450),
        .SHOTS        (2),
        .RESULT_FRAMES(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .left         (left),
        .xpos         (xpos),
        .ypos         (ypos),
        .vsync        (vsync),
        .screen_sel   (screen_sel),
        .shot_valid   (shot_valid),
        .shot_x       (shot_x),
        .shot_y       (shot_y),
        .goal         (goal),
        .keeper_sector(keeper_sector),
        .score        (score),
        .shots_taken  (shots_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard side: every shot_valid pulse must match the oldest queued shot.
    always @(posedge clk) begin
        #1;
        if (shot_valid === 1'b1) begin
            shot_t e;
            if (exp_q.size() == 0) begin
                chk("unexpected_shot_valid", 32'(shot_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("shot_x", 32'(shot_x), 32'(e.x));
                chk("shot_y", 32'(shot_y), 32'(e.y));
                chk("goal", 32'(goal), 32'(e.g));
                chk("keeper_sector", 32'(keeper_sector), 32'(e.k));
            end
        end
    end

    // One-cycle click in AIM; expected result queued as it is driven.
    task automatic shoot(input int x, input int y, input logic exp_goal);
        shot_t e;
        e.x = 12'(x);
        e.y = 12'(y);
        e.g = exp_goal;
        e.k = 2'd1;
        exp_q.push_back(e);
        xpos = 12'(x);
        ypos = 12'(y);
        left = 1'b1;
        step(1);
        left = 1'b0;
        chk("sel_after_shot", 32'(screen_sel), exp_goal ? 32'd2 : 32'd3);
        step(1);
        chk("shot_valid_one_cycle", 32'(shot_valid), 32'd0);
    endtask

    task automatic frame_tick();
        vsync = 1'b1;
        step(1);
        vsync = 1'b0;
        step(1);
    endtask

    initial begin
        rst   = 1'b1;
        left  = 1'b0;
        xpos  = 12'd0;
        ypos  = 12'd0;
        vsync = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);

        // Reset state.
        chk("rst_sel", 32'(screen_sel), 32'd0);
        chk("rst_valid", 32'(shot_valid), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_shots", 32'(shots_taken), 32'd0);
        chk("rst_keeper", 32'(keeper_sector), 32'd1);
        chk("rst_shot_x", 32'(shot_x), 32'd0);
        chk("rst_goal", 32'(goal), 32'd0);

        // START: click moves to AIM one cycle after the edge; held button is not a shot.
        left = 1'b1;
        step(1);
        chk("start_to_aim", 32'(screen_sel), 32'd1);
        step(100);
        chk("held_no_shot_sel", 32'(screen_sel), 32'd1);
        chk("held_no_shot_cnt", 32'(shots_taken), 32'd0);
        left = 1'b0;
        step(1);

        // Left third inside box scores against a centre keeper.
        shoot(250, 300, 1'b1);
        chk("shot1_score", 32'(score), 32'd1);
        chk("shot1_shots", 32'(shots_taken), 32'd1);
        frame_tick();
        chk("result_hold_1tick", 32'(screen_sel), 32'd2);
        frame_tick();
        chk("result_to_aim", 32'(screen_sel), 32'd1);

        // Centre shot saved; last shot of the round returns to START with totals held.
        shoot(500, 300, 1'b0);
        chk("shot2_score", 32'(score), 32'd1);
        chk("shot2_shots", 32'(shots_taken), 32'd2);
        frame_tick();
        frame_tick();
        chk("round_end_sel", 32'(screen_sel), 32'd0);
        chk("round_end_score", 32'(score), 32'd1);
        chk("round_end_shots", 32'(shots_taken), 32'd2);

        // New round clears totals.
        left = 1'b1;
        step(1);
        left = 1'b0;
        chk("new_round_sel", 32'(screen_sel), 32'd1);
        chk("new_round_score", 32'(score), 32'd0);
        chk("new_round_shots", 32'(shots_taken), 32'd0);
        step(1);

        // Right edge is exclusive.
        shoot(812, 300, 1'b0);

        // Click and tick together in RESULT: click ignored, tick counted.
        left  = 1'b1;
        vsync = 1'b1;
        step(1);
        left  = 1'b0;
        vsync = 1'b0;
        chk("click_in_result_sel", 32'(screen_sel), 32'd3);
        chk("click_in_result_shots", 32'(shots_taken), 32'd1);
        step(1);
        frame_tick();
        chk("coincident_tick_counted", 32'(screen_sel), 32'd1);

        // Left/top edges inclusive.
        shoot(212, 150, 1'b1);
        chk("edge_in_score", 32'(score), 32'd1);
        chk("edge_in_shots", 32'(shots_taken), 32'd2);

        // Reset pulse mid-RESULT aborts the round.
        frame_tick();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_sel", 32'(screen_sel), 32'd0);
        chk("midrst_score", 32'(score), 32'd0);
        chk("midrst_shots", 32'(shots_taken), 32'd0);
        chk("midrst_valid", 32'(shot_valid), 32'd0);
        step(1);

        // Right third inside box scores; bottom edge exclusive.
        left = 1'b1;
        step(1);
        left = 1'b0;
        step(1);
        shoot(811, 449, 1'b1);
        frame_tick();
        frame_tick();
        chk("aim_again", 32'(screen_sel), 32'd1);
        shoot(300, 450, 1'b0);
        chk("final_score", 32'(score), 32'd1);
        chk("final_shots", 32'(shots_taken), 32'd2);

        step(3);
        chk("all_shots_seen", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
